// File: rtl/urv_defs.sv
// Shared machine-mode trap definitions: CSR addresses, bit positions and cause codes.
package urv_defs;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_CYCLESL  = 12'hC00;
   localparam logic [11:0] CSR_TIMEL    = 12'hC01;
   localparam logic [11:0] CSR_CYCLESH  = 12'hC80;
   localparam logic [11:0] CSR_TIMEH    = 12'hC81;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;
   localparam int MIP_MTIP     = 7;
   localparam int MIP_MEIP     = 11;

   typedef enum logic [3:0] {
      EXC_MISALIGN_FETCH = 4'd0,
      EXC_ILLEGAL        = 4'd2,
      EXC_BREAKPOINT     = 4'd3,
      EXC_MISALIGN_LOAD  = 4'd4,
      EXC_MISALIGN_STORE = 4'd6,
      EXC_ECALL_M        = 4'd11
   } exc_cause_t;

   // Interrupt causes carry mcause[31]=1 on top of these codes.
   localparam logic [3:0] IRQ_CAUSE_TIMER = 4'd7;
   localparam logic [3:0] IRQ_CAUSE_EXT   = 4'd11;

endpackage

// File: rtl/urv_timer.sv
// Free-running 40-bit cycle counter plus prescaled 40-bit time counter.
// Counts every clock, never stalls; outputs are the registered counts.
module urv_timer #(
   parameter int TIME_DIV = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [39:0] o_cycles,
   output logic [39:0] o_time
);

   localparam int            PW     = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TIME_DIV - 1);

   logic [39:0]   r_cycles;
   logic [39:0]   r_time;
   logic [PW-1:0] r_presc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cycles <= '0;
         r_time   <= '0;
         r_presc  <= '0;
      end else begin
         r_cycles <= r_cycles + 40'd1;
         if (r_presc == P_LAST) begin
            r_presc <= '0;
            r_time  <= r_time + 40'd1;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
      end
   end

   assign o_cycles = r_cycles;
   assign o_time   = r_time;

endmodule

// File: rtl/urv_trap_unit.sv
// Machine-mode trap CSRs, exception/interrupt entry, mret and fetch redirect.
// Updates land one cycle after a committed instruction; stalled or killed instructions change nothing.
module urv_trap_unit
   import urv_defs::*;
#(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008,
   parameter int          TIME_DIV    = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_stall_i,
   input  logic        x_kill_i,
   input  logic        x_valid_i,
   input  logic [31:0] x_pc_i,
   input  logic        x_is_csr_i,
   input  logic [11:0] x_csr_sel_i,
   input  logic [31:0] x_csr_write_value_i,
   input  logic        x_exception_i,
   input  logic [3:0]  x_exception_cause_i,
   input  logic        x_is_mret_i,
   input  logic        irq_ext_i,
   input  logic        irq_timer_i,
   output logic [31:0] csr_mstatus_o,
   output logic [31:0] csr_mip_o,
   output logic [31:0] csr_mie_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mcause_o,
   output logic [39:0] csr_cycles_o,
   output logic [39:0] csr_time_o,
   output logic        x_trap_o,
   output logic [31:0] x_trap_pc_o
);

   logic        r_mie, r_mpie;
   logic        r_mtie, r_meie;
   logic        r_mtip, r_meip;
   logic [31:0] r_mepc;
   logic        r_mcause_irq;
   logic [3:0]  r_mcause_code;
   logic        r_trap;
   logic [31:0] r_trap_pc;

   logic w_commit, w_ext_pend, w_tmr_pend, w_irq_pend;

   assign w_commit   = x_valid_i & ~x_stall_i & ~x_kill_i;
   assign w_ext_pend = r_meip & r_meie;
   assign w_tmr_pend = r_mtip & r_mtie;
   assign w_irq_pend = r_mie & (w_ext_pend | w_tmr_pend);

   urv_timer #(.TIME_DIV(TIME_DIV)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .o_cycles (csr_cycles_o),
      .o_time   (csr_time_o)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mie         <= 1'b0;
         r_mpie        <= 1'b0;
         r_mtie        <= 1'b0;
         r_meie        <= 1'b0;
         r_mtip        <= 1'b0;
         r_meip        <= 1'b0;
         r_mepc        <= '0;
         r_mcause_irq  <= 1'b0;
         r_mcause_code <= '0;
         r_trap        <= 1'b0;
         r_trap_pc     <= '0;
      end else begin
         r_meip <= irq_ext_i;
         r_mtip <= irq_timer_i;
         r_trap <= 1'b0;
         if (w_commit) begin
            // An interrupt pre-empts the execute instruction, so it shares the exception entry path.
            if (x_exception_i || w_irq_pend) begin
               r_mepc    <= x_pc_i & ~32'h3;
               r_mpie    <= r_mie;
               r_mie     <= 1'b0;
               r_trap    <= 1'b1;
               r_trap_pc <= TRAP_VECTOR;
               if (x_exception_i) begin
                  r_mcause_irq  <= 1'b0;
                  r_mcause_code <= x_exception_cause_i;
               end else begin
                  r_mcause_irq  <= 1'b1;
                  r_mcause_code <= w_ext_pend ? IRQ_CAUSE_EXT : IRQ_CAUSE_TIMER;
               end
            end else if (x_is_mret_i) begin
               r_mie     <= r_mpie;
               r_mpie    <= 1'b1;
               r_trap    <= 1'b1;
               r_trap_pc <= r_mepc;
            end else if (x_is_csr_i) begin
               case (x_csr_sel_i)
                  CSR_MSTATUS: begin
                     r_mie  <= x_csr_write_value_i[MSTATUS_MIE];
                     r_mpie <= x_csr_write_value_i[MSTATUS_MPIE];
                  end
                  CSR_MIE: begin
                     r_mtie <= x_csr_write_value_i[MIE_MTIE];
                     r_meie <= x_csr_write_value_i[MIE_MEIE];
                  end
                  CSR_MEPC: r_mepc <= x_csr_write_value_i & ~32'h3;
                  CSR_MCAUSE: begin
                     r_mcause_irq  <= x_csr_write_value_i[31];
                     r_mcause_code <= x_csr_write_value_i[3:0];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      csr_mstatus_o               = '0;
      csr_mstatus_o[MSTATUS_MIE]  = r_mie;
      csr_mstatus_o[MSTATUS_MPIE] = r_mpie;
      csr_mie_o                   = '0;
      csr_mie_o[MIE_MTIE]         = r_mtie;
      csr_mie_o[MIE_MEIE]         = r_meie;
      csr_mip_o                   = '0;
      csr_mip_o[MIP_MTIP]         = r_mtip;
      csr_mip_o[MIP_MEIP]         = r_meip;
   end

   assign csr_mepc_o   = r_mepc;
   assign csr_mcause_o = {r_mcause_irq, 27'b0, r_mcause_code};
   assign x_trap_o     = r_trap;
   assign x_trap_pc_o  = r_trap_pc;

endmodule
